// File: rtl/vivaldi_pkg.sv
// Shared types and constants for the polyphonic vivaldi oscillator.
package vivaldi_pkg;

   typedef enum logic [2:0] {
      SINE     = 3'd0,
      SQUARE   = 3'd1,
      TRIANGLE = 3'd2,
      SAW      = 3'd3,
      NOISE    = 3'd4
   } wave_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_e;

   localparam logic [1:0] CFG_INC   = 2'd0;
   localparam logic [1:0] CFG_WAVE  = 2'd1;
   localparam logic [1:0] CFG_GAIN  = 2'd2;
   localparam logic [1:0] CFG_CLEAR = 2'd3;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Galois right-shift step of the shared noise register.
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/vivaldi_wave_shaper.sv
// Maps one voice's phase to a signed waveform sample, registered; holds the sine ROM.
module vivaldi_wave_shaper
   import vivaldi_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int PHASE_W = 24,
   parameter int LUT_AW  = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [PHASE_W-1:0]      phase_i,
   input  logic [2:0]              wave_i,
   input  logic [15:0]             lfsr_i,
   output logic signed [WIDTH-1:0] sample_o
);

   localparam int  N     = 2 ** LUT_AW;
   localparam int  MAX_I = (2 ** (WIDTH - 1)) - 1;
   localparam real PI    = 3.14159265358979323846;
   localparam logic signed [WIDTH-1:0] MAX_S = WIDTH'(MAX_I);
   localparam logic [WIDTH-1:0]        MID_U = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [WIDTH-1:0] rom_s [N];
   logic [WIDTH-1:0]        p_s;
   logic [WIDTH-2:0]        q_s;
   logic [WIDTH-2:0]        t_s;
   logic signed [WIDTH-1:0] sample_d;
   logic signed [WIDTH-1:0] sample_q;
   logic                    unused_s;

   // Full-wave table, rounded half away from zero.
   for (genvar k = 0; k < N; k++) begin : g_rom
      localparam real AMP = real'(MAX_I) * $sin(2.0 * PI * real'(k) / real'(N));
      localparam int  VAL = (AMP >= 0.0) ? $rtoi(AMP + 0.5) : -$rtoi(0.5 - AMP);
      assign rom_s[k] = WIDTH'(VAL);
   end

   assign unused_s = ^{phase_i, lfsr_i};

   // waveform select
   always_comb begin
      p_s      = phase_i[PHASE_W-1 -: WIDTH];
      q_s      = p_s[WIDTH-2:0];
      t_s      = p_s[WIDTH-1] ? ~q_s : q_s;
      sample_d = {WIDTH{1'b0}};
      case (wave_i)
         SINE:     sample_d = rom_s[phase_i[PHASE_W-1 -: LUT_AW]];
         SQUARE:   sample_d = p_s[WIDTH-1] ? -MAX_S : MAX_S;
         TRIANGLE: sample_d = {t_s, 1'b0} - MID_U;
         SAW:      sample_d = p_s ^ MID_U;
         NOISE:    sample_d = lfsr_i[15 -: WIDTH];
         default:  sample_d = {WIDTH{1'b0}};
      endcase
   end

   // output register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sample_q <= {WIDTH{1'b0}};
      end else begin
         sample_q <= sample_d;
      end
   end

   assign sample_o = sample_q;

endmodule

// File: rtl/vivaldi_poly_osc.sv
// Time-multiplexed polyphonic oscillator: one voice per cycle, mixed, saturated and streamed out.
module vivaldi_poly_osc
   import vivaldi_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int WIDTH      = 16,
   parameter int PHASE_W    = 24,
   parameter int LUT_AW     = 8,
   localparam int VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    tick_i,
   input  logic                    cfg_valid_i,
   input  logic [VW-1:0]           cfg_voice_i,
   input  logic [1:0]              cfg_addr_i,
   input  logic [PHASE_W-1:0]      cfg_data_i,
   output logic signed [WIDTH-1:0] sample_o,
   output logic                    sample_valid_o,
   input  logic                    sample_ready_i,
   output logic                    clip_o,
   output logic                    overrun_o
);

   localparam int AW = WIDTH + $clog2(NUM_VOICES) + 1;
   localparam logic [VW-1:0]        LAST   = VW'(NUM_VOICES - 1);
   localparam logic signed [AW-1:0] SAT_HI = AW'((2 ** (WIDTH - 1)) - 1);
   localparam logic signed [AW-1:0] SAT_LO = AW'(-(2 ** (WIDTH - 1)));

   state_e                  state_q, state_d;
   logic [VW-1:0]           idx_q, idx_d;
   logic [PHASE_W-1:0]      phase_q [NUM_VOICES];
   logic [PHASE_W-1:0]      phase_d [NUM_VOICES];
   logic [PHASE_W-1:0]      inc_q   [NUM_VOICES];
   logic [PHASE_W-1:0]      inc_d   [NUM_VOICES];
   logic [2:0]              wave_q  [NUM_VOICES];
   logic [2:0]              wave_d  [NUM_VOICES];
   logic                    en_q    [NUM_VOICES];
   logic                    en_d    [NUM_VOICES];
   logic [7:0]              gain_q  [NUM_VOICES];
   logic [7:0]              gain_d  [NUM_VOICES];
   logic [7:0]              gain_pipe_q, gain_pipe_d;
   logic signed [AW-1:0]    acc_q, acc_d;
   logic [15:0]             lfsr_q, lfsr_d;
   logic signed [WIDTH-1:0] sample_q, sample_d;
   logic                    valid_q, valid_d;
   logic                    clip_q, clip_d;
   logic                    overrun_q, overrun_d;

   logic signed [WIDTH-1:0] shape_s;
   logic signed [WIDTH+8:0] mult_s;
   logic signed [AW-1:0]    prod_s;
   logic signed [AW-1:0]    total_s;

   vivaldi_wave_shaper #(
      .WIDTH   (WIDTH),
      .PHASE_W (PHASE_W),
      .LUT_AW  (LUT_AW)
   ) u_shaper (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .phase_i  (phase_q[idx_q]),
      .wave_i   (wave_q[idx_q]),
      .lfsr_i   (lfsr_q),
      .sample_o (shape_s)
   );

   // gain_pipe_q travels with the shaper output; it is zero for disabled voices and bubbles
   assign mult_s  = shape_s * $signed({1'b0, gain_pipe_q});
   assign prod_s  = AW'(mult_s >>> 4'd8);
   assign total_s = acc_q + prod_s;

   // frame sequencing, mixing, output handshake and config writes
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      phase_d     = phase_q;
      inc_d       = inc_q;
      wave_d      = wave_q;
      en_d        = en_q;
      gain_d      = gain_q;
      gain_pipe_d = 8'd0;
      acc_d       = acc_q;
      lfsr_d      = lfsr_q;
      sample_d    = sample_q;
      valid_d     = valid_q;
      clip_d      = clip_q;
      overrun_d   = overrun_q;

      case (state_q)
         IDLE: begin
            if (tick_i) begin
               state_d = RUN;
               idx_d   = '0;
               acc_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            acc_d = total_s;
            if (en_q[idx_q]) begin
               gain_pipe_d           = gain_q[idx_q];
               phase_d[idx_q]        = phase_q[idx_q] + inc_q[idx_q];
            end else begin
               gain_pipe_d           = 8'd0;
            end
            if (idx_q == LAST) begin
               state_d = DRAIN;
            end else begin
               idx_d   = idx_q + 1'b1;
            end
            if (tick_i) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_q;
            end
         end
         DRAIN: begin
            if (total_s > SAT_HI) begin
               sample_d = SAT_HI[WIDTH-1:0];
               clip_d   = 1'b1;
            end else if (total_s < SAT_LO) begin
               sample_d = SAT_LO[WIDTH-1:0];
               clip_d   = 1'b1;
            end else begin
               sample_d = total_s[WIDTH-1:0];
               clip_d   = 1'b0;
            end
            valid_d = 1'b1;
            lfsr_d  = lfsr_next(lfsr_q);
            state_d = OUT;
            if (tick_i) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_q;
            end
         end
         OUT: begin
            // a tick arriving with the accepting ready starts the next frame directly
            if (sample_ready_i) begin
               valid_d = 1'b0;
               if (tick_i) begin
                  state_d = RUN;
                  idx_d   = '0;
                  acc_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (tick_i) begin
                  overrun_d = 1'b1;
               end else begin
                  overrun_d = overrun_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (cfg_valid_i) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (cfg_voice_i == VW'(v)) begin
               case (cfg_addr_i)
                  CFG_INC:   inc_d[v]   = cfg_data_i;
                  CFG_WAVE: begin
                     wave_d[v] = cfg_data_i[2:0];
                     en_d[v]   = cfg_data_i[3];
                  end
                  CFG_GAIN:  gain_d[v]  = cfg_data_i[7:0];
                  CFG_CLEAR: phase_d[v] = '0;
                  default:   inc_d[v]   = inc_q[v];
               endcase
            end else begin
               inc_d[v] = inc_d[v];
            end
         end
      end else begin
         inc_d = inc_d;
      end
   end

   // state registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         phase_q     <= '{default: '0};
         inc_q       <= '{default: '0};
         wave_q      <= '{default: SINE};
         en_q        <= '{default: 1'b0};
         gain_q      <= '{default: 8'd0};
         gain_pipe_q <= 8'd0;
         acc_q       <= '0;
         lfsr_q      <= LFSR_SEED;
         sample_q    <= '0;
         valid_q     <= 1'b0;
         clip_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         phase_q     <= phase_d;
         inc_q       <= inc_d;
         wave_q      <= wave_d;
         en_q        <= en_d;
         gain_q      <= gain_d;
         gain_pipe_q <= gain_pipe_d;
         acc_q       <= acc_d;
         lfsr_q      <= lfsr_d;
         sample_q    <= sample_d;
         valid_q     <= valid_d;
         clip_q      <= clip_d;
         overrun_q   <= overrun_d;
      end
   end

   assign sample_o       = sample_q;
   assign sample_valid_o = valid_q;
   assign clip_o         = clip_q;
   assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_vivaldi_poly_osc.sv
// Self-checking bench: table of single-voice frames plus hand-written mix, backpressure and reset cases.
`timescale 1ns/1ps
module tb_vivaldi_poly_osc;

   localparam int NV = 4;
   localparam int W  = 16;
   localparam int PW = 24;
   localparam int LA = 8;

   localparam logic [2:0] W_SINE = 3'd0;
   localparam logic [2:0] W_SQ   = 3'd1;
   localparam logic [2:0] W_TRI  = 3'd2;
   localparam logic [2:0] W_SAW  = 3'd3;
   localparam logic [2:0] W_NOI  = 3'd4;
   localparam logic [2:0] W_BAD  = 3'd5;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic                tick_i;
   logic                cfg_valid_i;
   logic [1:0]          cfg_voice_i;
   logic [1:0]          cfg_addr_i;
   logic [PW-1:0]       cfg_data_i;
   logic signed [W-1:0] sample_o;
   logic                sample_valid_o;
   logic                sample_ready_i;
   logic                clip_o;
   logic                overrun_o;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int sample;
      int clip;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [2:0]    wave;
      logic          en;
      logic [7:0]    gain;
      logic [PW-1:0] inc;
      int            sample;
      int            clip;
   } vec_t;
   vec_t vecs[19];

   always #5 clk_i = ~clk_i;

   vivaldi_poly_osc #(
      .NUM_VOICES (NV),
      .WIDTH      (W),
      .PHASE_W    (PW),
      .LUT_AW     (LA)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .tick_i         (tick_i),
      .cfg_valid_i    (cfg_valid_i),
      .cfg_voice_i    (cfg_voice_i),
      .cfg_addr_i     (cfg_addr_i),
      .cfg_data_i     (cfg_data_i),
      .sample_o       (sample_o),
      .sample_valid_o (sample_valid_o),
      .sample_ready_i (sample_ready_i),
      .clip_o         (clip_o),
      .overrun_o      (overrun_o)
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic reset_dut();
      rst_i          = 1'b1;
      tick_i         = 1'b0;
      cfg_valid_i    = 1'b0;
      cfg_voice_i    = 2'd0;
      cfg_addr_i     = 2'd0;
      cfg_data_i     = '0;
      sample_ready_i = 1'b1;
      step();
      step();
      rst_i = 1'b0;
   endtask

   task automatic cfg_write(input int v, input logic [1:0] a, input logic [PW-1:0] d);
      cfg_voice_i = 2'(v);
      cfg_addr_i  = a;
      cfg_data_i  = d;
      cfg_valid_i = 1'b1;
      step();
      cfg_valid_i = 1'b0;
   endtask

   task automatic set_voice(input int v, input logic [2:0] wv, input logic en,
                            input logic [7:0] g, input logic [PW-1:0] inc);
      cfg_write(v, 2'd1, {20'd0, en, wv});
      cfg_write(v, 2'd2, {16'd0, g});
      cfg_write(v, 2'd0, inc);
   endtask

   // Tick, expect valid NV+1 edges after the edge that samples the tick, compare, handshake.
   task automatic run_frame(input string name, input int exp_s, input int exp_c);
      exp_t e;
      int   cyc;
      bit   seen;
      sb_q.push_back('{sample: exp_s, clip: exp_c});
      tick_i = 1'b1;
      step();
      tick_i = 1'b0;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 20) begin
         step();
         cyc++;
         if (sample_valid_o) seen = 1'b1;
      end
      check({name, " latency"}, cyc, NV + 1);
      e = sb_q.pop_front();
      if (seen) begin
         check({name, " sample"}, int'(sample_o), e.sample);
         check({name, " clip"}, int'(clip_o), e.clip);
      end else begin
         tests++;
         fails++;
         $display("FAIL %s timeout: valid never rose, expected sample %0d", name, e.sample);
      end
      if (sample_ready_i) begin
         step();
         check({name, " valid drop"}, int'(sample_valid_o), 0);
      end
   endtask

   initial begin
      int vcount;

      vecs[0]  = '{W_SQ,   1'b1, 8'd255, 24'h400000,  32639, 0};
      vecs[1]  = '{W_SQ,   1'b1, 8'd255, 24'h400000,  32639, 0};
      vecs[2]  = '{W_SQ,   1'b1, 8'd255, 24'h400000, -32640, 0};
      vecs[3]  = '{W_SQ,   1'b1, 8'd255, 24'h400000, -32640, 0};
      vecs[4]  = '{W_SINE, 1'b1, 8'd255, 24'h400000,      0, 0};
      vecs[5]  = '{W_SINE, 1'b1, 8'd255, 24'h400000,  32639, 0};
      vecs[6]  = '{W_SINE, 1'b1, 8'd255, 24'h400000,      0, 0};
      vecs[7]  = '{W_SINE, 1'b1, 8'd255, 24'h400000, -32640, 0};
      vecs[8]  = '{W_TRI,  1'b1, 8'd255, 24'h200000, -32640, 0};
      vecs[9]  = '{W_TRI,  1'b1, 8'd255, 24'h200000, -16320, 0};
      vecs[10] = '{W_TRI,  1'b1, 8'd255, 24'h200000,      0, 0};
      vecs[11] = '{W_TRI,  1'b1, 8'd255, 24'h200000,  16320, 0};
      vecs[12] = '{W_TRI,  1'b1, 8'd255, 24'h200000,  32638, 0};
      vecs[13] = '{W_SAW,  1'b1, 8'd255, 24'h200000,   8160, 0};
      vecs[14] = '{W_SAW,  1'b1, 8'd128, 24'h200000,   8192, 0};
      vecs[15] = '{W_BAD,  1'b1, 8'd255, 24'h200000,      0, 0};
      vecs[16] = '{W_SQ,   1'b0, 8'd255, 24'h200000,      0, 0};
      vecs[17] = '{W_SQ,   1'b1, 8'd255, 24'h200000,  32639, 0};
      vecs[18] = '{W_SQ,   1'b1, 8'd128, 24'h200000,  16383, 0};

      reset_dut();
      check("reset sample", int'(sample_o), 0);
      check("reset valid", int'(sample_valid_o), 0);
      check("reset clip", int'(clip_o), 0);
      check("reset overrun", int'(overrun_o), 0);
      run_frame("silent", 0, 0);

      reset_dut();
      set_voice(0, W_NOI, 1'b1, 8'd255, 24'h000000);
      run_frame("noise seed", -21196, 0);
      run_frame("noise next", -7539, 0);

      reset_dut();
      for (int i = 0; i < 19; i++) begin
         set_voice(0, vecs[i].wave, vecs[i].en, vecs[i].gain, vecs[i].inc);
         run_frame($sformatf("vec%0d", i), vecs[i].sample, vecs[i].clip);
      end

      reset_dut();
      for (int v = 0; v < NV; v++) set_voice(v, W_SQ, 1'b1, 8'd255, 24'h000000);
      run_frame("four square", 32767, 1);
      cfg_write(2, 2'd1, {20'd0, 1'b0, W_SQ});
      run_frame("three square", 32767, 1);
      cfg_write(1, 2'd1, {20'd0, 1'b1, W_SAW});
      cfg_write(3, 2'd1, {20'd0, 1'b0, W_SQ});
      run_frame("square plus saw", -1, 0);
      for (int v = 0; v < NV; v++) cfg_write(v, 2'd1, {20'd0, 1'b1, W_SAW});
      run_frame("four saw", -32768, 1);

      check("overrun before", int'(overrun_o), 0);
      sample_ready_i = 1'b0;
      run_frame("held", -32768, 1);
      tick_i = 1'b1;
      step();
      tick_i = 1'b0;
      check("overrun set", int'(overrun_o), 1);
      check("held valid", int'(sample_valid_o), 1);
      check("held sample", int'(sample_o), -32768);
      step();
      check("held sample later", int'(sample_o), -32768);
      sample_ready_i = 1'b1;
      step();
      check("held release", int'(sample_valid_o), 0);
      check("overrun sticky", int'(overrun_o), 1);

      cfg_write(0, 2'd0, 24'h100000);
      tick_i = 1'b1;
      step();
      tick_i = 1'b0;
      step();
      step();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      vcount = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (sample_valid_o) vcount++;
      end
      check("abort no valid", vcount, 0);
      check("abort sample", int'(sample_o), 0);
      check("abort clip", int'(clip_o), 0);
      check("abort overrun", int'(overrun_o), 0);
      set_voice(0, W_NOI, 1'b1, 8'd255, 24'h000000);
      run_frame("abort lfsr", -21196, 0);
      cfg_write(0, 2'd1, {20'd0, 1'b1, W_SAW});
      run_frame("abort phase", -32640, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
